// File: rtl/riscv_fetch_align.sv
// Fetch-alignment buffer: aligned fetch beats go into a halfword ring, and one 16/32-bit instruction is decoded at the head.
// Optional compressed (RVC) decode is enabled by defining RISCV_RVC_EN.
module riscv_fetch_align #(
  parameter int FETCH_W = 32,
  parameter int DEPTH   = 8,
  parameter int SEQ_W   = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush_i,
  input  logic [31:0]        flush_addr_i,
  input  logic               fetch_valid_i,
  output logic               fetch_ready_o,
  input  logic [31:0]        fetch_addr_i,
  input  logic [FETCH_W-1:0] fetch_data_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [31:0]        out_addr_o,
  output logic [31:0]        out_data_o,
  output logic               out_compressed_o,
  output logic               out_illegal_o,
  output logic [SEQ_W-1:0]   out_seq_o
);

  localparam int NH     = FETCH_W / 16;
  localparam int NB     = FETCH_W / 8;
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int SKIP_W = $clog2(NH);
  localparam int OFS_W  = $clog2(NB);

  logic [15:0]       ring_q [DEPTH];
  logic [15:0]       ring_d [DEPTH];
  logic [PTR_W-1:0]  rd_q, rd_d;
  logic [PTR_W-1:0]  wr_q, wr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [31:0]       pc_q, pc_d;
  logic [31:0]       fetch_exp_q, fetch_exp_d;
  logic [SKIP_W-1:0] skip_q, skip_d;
  logic [SEQ_W-1:0]  seq_q, seq_d;

  logic [15:0]       h0, h1;
  logic              is32;
  logic              head_ok;
  logic [31:0]       inst;
  logic              push, pop;
  logic [CNT_W-1:0]  push_n, pop_n;
  logic [31:0]       flush_pc;

  always_comb begin : head_decode
    h0 = ring_q[rd_q];
    h1 = ring_q[rd_q + PTR_W'(1)];
`ifdef RISCV_RVC_EN
    is32 = (h0[1:0] == 2'b11);
`else
    is32 = 1'b1;
`endif
    head_ok = is32 ? (count_q >= CNT_W'(2)) : (count_q != '0);
    inst    = is32 ? {h1, h0} : {16'h0000, h0};
  end

  // Both sides use valid/ready: a transfer happens on the rising edge where valid and ready are
  // both high; valid never waits on ready. fetch_ready_o only credits the registered count.
  assign fetch_ready_o = !flush_i && ((CNT_W'(DEPTH) - count_q) >= CNT_W'(NH));
  assign out_valid_o   = head_ok;
  assign out_addr_o    = pc_q;
  assign out_seq_o     = seq_q;
  assign out_data_o    = head_ok ? inst : 32'h0;

`ifdef RISCV_RVC_EN
  assign out_compressed_o = head_ok && !is32;
  assign out_illegal_o    = head_ok && (inst == 32'h0);
  assign flush_pc         = {flush_addr_i[31:1], 1'b0};
`else
  assign out_compressed_o = 1'b0;
  assign out_illegal_o    = head_ok && ((inst == 32'h0) || (h0[1:0] != 2'b11));
  assign flush_pc         = {flush_addr_i[31:2], 2'b00};
`endif

  always_comb begin : next_state
    ring_d      = ring_q;
    rd_d        = rd_q;
    wr_d        = wr_q;
    count_d     = count_q;
    pc_d        = pc_q;
    fetch_exp_d = fetch_exp_q;
    skip_d      = skip_q;
    seq_d       = seq_q;
    // A beat at an unexpected address is still accepted, but only so that it is thrown away.
    push   = fetch_valid_i && fetch_ready_o && (fetch_addr_i == fetch_exp_q);
    pop    = head_ok && out_ready_i;
    push_n = push ? (CNT_W'(NH) - CNT_W'(skip_q)) : '0;
    pop_n  = pop ? (is32 ? CNT_W'(2) : CNT_W'(1)) : '0;
    if (flush_i) begin
      rd_d        = '0;
      wr_d        = '0;
      count_d     = '0;
      pc_d        = flush_pc;
      fetch_exp_d = {flush_pc[31:OFS_W], OFS_W'(0)};
      skip_d      = flush_pc[OFS_W-1:1];
    end else begin
      if (push) begin
        for (int i = 0; i < NH; i++) begin
          if (SKIP_W'(i) >= skip_q) begin
            ring_d[wr_q + PTR_W'(i) - PTR_W'(skip_q)] = fetch_data_i[16*i +: 16];
          end
        end
        wr_d        = wr_q + PTR_W'(push_n);
        skip_d      = '0;
        fetch_exp_d = fetch_exp_q + 32'(NB);
      end
      if (pop) begin
        rd_d  = rd_q + PTR_W'(pop_n);
        pc_d  = pc_q + (is32 ? 32'd4 : 32'd2);
        seq_d = seq_q + SEQ_W'(1);
      end
      count_d = count_q + push_n - pop_n;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) ring_q[i] <= 16'h0000;
      rd_q        <= '0;
      wr_q        <= '0;
      count_q     <= '0;
      pc_q        <= 32'h0;
      fetch_exp_q <= 32'h0;
      skip_q      <= '0;
      seq_q       <= '0;
    end else begin
      ring_q      <= ring_d;
      rd_q        <= rd_d;
      wr_q        <= wr_d;
      count_q     <= count_d;
      pc_q        <= pc_d;
      fetch_exp_q <= fetch_exp_d;
      skip_q      <= skip_d;
      seq_q       <= seq_d;
    end
  end

endmodule

// File: doc/riscv_fetch_align.md
Name: riscv_fetch_align

Overview:
- Parametrised fetch-alignment buffer between instruction memory and decode.
- Accepts aligned fetch beats of FETCH_W bits and stores them as halfwords in a circular buffer.
- Extracts one 16-bit (RVC) or 32-bit instruction per cycle, with address, sequence number and illegal flag.
- Successor to the fixed 32-bit addr/data fetch record: width, depth and compressed support are configurable, and it adds buffering and flow control.

Parameters:
- FETCH_W, 32, fetch beat width in bits; 32 or 64.
- DEPTH, 8, buffer capacity in halfwords; power of two, >= 2*FETCH_W/16.
- SEQ_W, 64, width of instruction sequence counter.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- flush_i  input  1  redirect; discard buffer contents and restart at flush_addr_i.
- flush_addr_i  input  32  new PC.
- fetch_valid_i  input  1  fetch beat valid.
- fetch_ready_o  output  1  buffer can accept a full beat.
- fetch_addr_i  input  32  beat address, aligned to FETCH_W/8.
- fetch_data_i  input  FETCH_W  beat data, little-endian halfwords.
- out_valid_o  output  1  complete instruction at buffer head.
- out_ready_i  input  1  decode accepts instruction.
- out_addr_o  output  32  instruction address.
- out_data_o  output  32  instruction bits; upper 16 zero for RVC.
- out_compressed_o  output  1  instruction is 16-bit.
- out_illegal_o  output  1  alignment-level illegal encoding.
- out_seq_o  output  SEQ_W  sequence number of the presented instruction.

Behaviour:
- Reset values: buffer empty, count 0, pc 0, expected fetch address 0, seq 0. Outputs: out_valid_o 0, fetch_ready_o 1, out_* data 0.
- State: halfword ring (rd/wr pointers mod DEPTH), count, pc (address of head halfword), fetch_exp (next expected beat address), skip (halfwords to drop from next beat).
- Accept condition: fetch_valid_i && fetch_ready_o.
  - fetch_ready_o = !flush_i && (DEPTH - count) >= FETCH_W/16.
  - fetch_ready_o uses the registered count; a same-cycle pop is not credited.
- Accepted beat, address match (fetch_addr_i == fetch_exp):
  - Halfwords from index skip upward are written in ascending address order.
  - skip is then cleared; fetch_exp += FETCH_W/8.
- Accepted beat, address mismatch: the beat is consumed and dropped, no state change. This flushes stale in-flight fetches.
- Head decode:
  - h0 = head halfword. If h0[1:0]==2'b11, the instruction is 32-bit and needs count>=2; otherwise 16-bit, needs count>=1.
  - out_valid_o = requirement met. A 32-bit instruction split across beats holds out_valid_o low until the second half is written.
- Latency: a beat accepted in cycle N is visible at the output in cycle N+1 (registered buffer, combinational head decode).
- Out handshake (out_valid_o && out_ready_i):
  - Pops 1 or 2 halfwords; pc += 2 or 4, with 32-bit wrap (0xFFFFFFFE+2 = 0); seq += 1.
  - Push and pop in the same cycle are both performed; count updates by the net amount.
- Flush (highest priority):
  - Buffer cleared; pc = flush_addr_i with bit0 = 0.
  - fetch_exp = flush_addr_i aligned down to FETCH_W/8.
  - skip = (flush_addr_i mod FETCH_W/8)/2.
  - A same-cycle out handshake is discarded and seq is not incremented. seq is never reset by flush.
  - out_valid_o is 0 in the cycle after the flush.
- out_illegal_o: set when out_data_o==32'h0 (all-zero halfword, 16-bit form); still handshakes normally.
- rst asserted mid-operation: all state returns to reset values on the next edge regardless of other inputs.

Optional Feature:
- Macro: RISCV_RVC_EN.
- Defined: 16-bit decode as above.
- Undefined:
  - Every instruction is 32-bit and needs two halfwords; out_compressed_o tied 0.
  - flush_addr_i bit1 is also forced to 0.
  - out_illegal_o is also set when h0[1:0]!=2'b11; the instruction is still consumed as 4 bytes.

Test Plan:
1. Reset, flush to 0x100, beats 0x100=0x00A00093, 0x104=0x00108113, out_ready_i=1 -> two outputs at 0x100/0x104, seq 0 and 1, out_compressed_o=0, one cycle after each beat.
2. RVC_EN, beat 0x200=0x0505_4501 -> 0x200 data 0x4501 compressed, then 0x202 data 0x0505 compressed.
3. Straddle: flush to 0x302, beat 0x300=0x0093_xxxx -> out_valid_o stays 0; beat 0x304 low halfword 0x00A0 -> output 0x302 data 0x00A00093.
4. Backpressure: out_ready_i=0, FETCH_W=32, DEPTH=8 -> fetch_ready_o drops after 4 beats; one 32-bit pop -> fetch_ready_o returns 1 the next cycle.
5. Flush with buffered data and a simultaneous handshake -> seq unchanged, a stale beat at the old address is dropped, first output at the new PC.
6. Without RVC_EN, beat 0x400=0x00004501 -> out_illegal_o=1, next pc 0x404.
